// File: rtl/adc_conv_scheduler.sv
// ---------------------------------------------------------------------------
// adc_conv_scheduler
//   Shares one SAR-ADC digital core between NUM_REQ requesters. Pending
//   requests are arbitrated round-robin. For each accepted request the block
//   applies that requester's config word and holds the core in reset for
//   SETUP_CYCLES cycles. It then releases the core and waits for the core's
//   conversion-finished strobe, or gives up after TIMEOUT_CYCLES. Finally it
//   returns the 16-bit result tagged with the requester ID.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   req_in            level request per requester, held until granted
//   cfg_in            per-requester {osr_mode[2:0], avg_control[2:0]}, slice i = [6i+5:6i]
//   grant_out         one-hot 1-cycle pulse when a request is accepted
//   busy_out          high whenever the scheduler is not idle
//   result_valid_out  1-cycle pulse qualifying result_out/result_id_out/timeout_out
//   result_out        captured conversion result (0 on timeout)
//   result_id_out     requester ID of the returned result
//   timeout_out       conversion was aborted by the timeout
//   core_rst_n_out    active-low reset to the ADC core
//   core_config_out   {10'b0, osr_mode, avg_control} of the granted requester
//   core_finished_in  core conversion-finished strobe (asynchronous to clk)
//   core_result_in    core result, stable while core_finished_in is high
// ---------------------------------------------------------------------------
module adc_conv_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int SETUP_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 4095,
    localparam int IDW           = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_in,
    input  logic [6*NUM_REQ-1:0] cfg_in,
    output logic [NUM_REQ-1:0]   grant_out,
    output logic                 busy_out,
    output logic                 result_valid_out,
    output logic [15:0]          result_out,
    output logic [IDW-1:0]       result_id_out,
    output logic                 timeout_out,
    output logic                 core_rst_n_out,
    output logic [15:0]          core_config_out,
    input  logic                 core_finished_in,
    input  logic [15:0]          core_result_in
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [15:0]        r_cnt;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_id;
    logic [IDW-1:0]     r_res_id;
    logic [15:0]        r_cfg;
    logic [15:0]        r_result;
    logic               r_valid;
    logic               r_timeout;
    logic               r_core_rst_n;

    // Two-FF synchronizer plus one history flop for edge detection.
    logic               r_fin_s1;
    logic               r_fin_s2;
    logic               r_fin_s3;
    logic               w_done;

    logic               w_any;
    logic [IDW-1:0]     w_pick;
    logic [NUM_REQ-1:0] w_grant;

    // Only a rising edge of the synchronized strobe counts. A level that is
    // already high when RUN is entered produces no edge and is ignored.
    assign w_done = r_fin_s2 & ~r_fin_s3;

    // Round-robin pick: the first set request at or after r_ptr, wrapping.
    always_comb begin : arb
        int idx;
        idx    = 0;
        w_any  = 1'b0;
        w_pick = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_any && req_in[idx]) begin
                w_any  = 1'b1;
                w_pick = IDW'(idx);
            end
        end
    end

    // The grant is combinational so that it appears in the IDLE cycle itself.
    // It is masked while reset is asserted, so reset always shows grant_out = 0.
    always_comb begin
        w_grant = '0;
        if (r_state == S_IDLE && w_any && !rst)
            w_grant[w_pick] = 1'b1;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_SETUP;
            S_SETUP: if (r_cnt == '0) w_next = S_RUN;
            S_RUN:   if (w_done || r_cnt == '0) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fin_s1     <= 1'b0;
            r_fin_s2     <= 1'b0;
            r_fin_s3     <= 1'b0;
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_id         <= '0;
            r_res_id     <= '0;
            r_cfg        <= '0;
            r_result     <= '0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_fin_s1 <= core_finished_in;
            r_fin_s2 <= r_fin_s1;
            r_fin_s3 <= r_fin_s2;
            r_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id  <= w_pick;
                        r_cfg <= {10'b0, cfg_in[6*int'(w_pick) +: 6]};
                        r_cnt <= 16'(SETUP_CYCLES - 1);
                        r_ptr <= (int'(w_pick) == NUM_REQ - 1) ? '0 : w_pick + 1'b1;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_core_rst_n <= 1'b1;
                        r_cnt        <= 16'(TIMEOUT_CYCLES - 1);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    // A done edge takes priority over expiry in the same cycle.
                    if (w_done) begin
                        r_result     <= core_result_in;
                        r_timeout    <= 1'b0;
                        r_valid      <= 1'b1;
                        r_res_id     <= r_id;
                        r_core_rst_n <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_result     <= '0;
                        r_timeout    <= 1'b1;
                        r_valid      <= 1'b1;
                        r_res_id     <= r_id;
                        r_core_rst_n <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant_out        = w_grant;
    assign busy_out         = (r_state != S_IDLE);
    assign result_valid_out = r_valid;
    assign result_out       = r_result;
    assign result_id_out    = r_res_id;
    assign timeout_out      = r_timeout;
    assign core_rst_n_out   = r_core_rst_n;
    assign core_config_out  = r_cfg;

endmodule
